// File: rtl/id_ex_pipe_reg_if.sv
// rtl/id_ex_pipe_reg_if.sv - ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_pipe_reg_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] if_id_rs1;
  logic [REG_AW-1:0] if_id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [XLEN-1:0]   id_pc;
  logic [8:0]        id_ctrl;
  logic              id_valid;
  logic              ex_flush;

  logic [REG_AW-1:0] id_ex_rs1;
  logic [REG_AW-1:0] id_ex_rs2;
  logic [REG_AW-1:0] id_ex_rd;
  logic [XLEN-1:0]   id_ex_rs1_data;
  logic [XLEN-1:0]   id_ex_rs2_data;
  logic [XLEN-1:0]   id_ex_imm;
  logic [XLEN-1:0]   id_ex_pc;
  logic [8:0]        id_ex_ctrl;
  logic              id_ex_valid;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, id_pc, id_ctrl, id_valid, ex_flush,
    input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_rs1_data, id_ex_rs2_data,
           id_ex_imm, id_ex_pc, id_ex_ctrl, id_ex_valid, stall, stall_count
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm, id_pc, id_ctrl, id_valid, ex_flush,
    output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_rs1_data, id_ex_rs2_data,
           id_ex_imm, id_ex_pc, id_ex_ctrl, id_ex_valid, stall, stall_count
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use hazard stall and stall counter
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_pipe_reg_if.slave  bus
);
  localparam int MEMREAD_BIT = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d;
  logic [8:0]        ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hz;
  logic              stall;

  // Hazard looks only at what EX holds now and which registers ID actually reads.
  always_comb begin
    hz = valid_q & ctrl_q[MEMREAD_BIT] & (rd_q != '0) &
         ((bus.id_uses_rs1 & (bus.if_id_rs1 == rd_q)) |
          (bus.id_uses_rs2 & (bus.if_id_rs2 == rd_q)));
    stall = hz & ~bus.ex_flush;
  end

  always_comb begin
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    pc_d       = '0;
    ctrl_d     = '0;
    valid_d    = 1'b0;
    if (!(bus.ex_flush || hz)) begin
      rs1_d      = bus.if_id_rs1;
      rs2_d      = bus.if_id_rs2;
      rd_d       = bus.id_rd;
      rs1_data_d = bus.id_rs1_data;
      rs2_data_d = bus.id_rs2_data;
      imm_d      = bus.id_imm;
      pc_d       = bus.id_pc;
      ctrl_d     = bus.id_valid ? bus.id_ctrl : 9'h000;
      valid_d    = bus.id_valid;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.id_ex_rs1      = rs1_q;
  assign bus.id_ex_rs2      = rs2_q;
  assign bus.id_ex_rd       = rd_q;
  assign bus.id_ex_rs1_data = rs1_data_q;
  assign bus.id_ex_rs2_data = rs2_data_q;
  assign bus.id_ex_imm      = imm_q;
  assign bus.id_ex_pc       = pc_q;
  assign bus.id_ex_ctrl     = ctrl_q;
  assign bus.id_ex_valid    = valid_q;
  assign bus.stall          = stall;
  assign bus.stall_count    = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.XLEN(32), .REG_AW(5), .CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.XLEN(32), .REG_AW(5), .CNT_W(2))  bus2 ();

  id_ex_pipe_reg #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  id_ex_pipe_reg #(.XLEN(32), .REG_AW(5), .CNT_W(2))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic [8:0] ctrl,
                       input logic valid);
    bus.if_id_rs1   = rs1;
    bus.if_id_rs2   = rs2;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
    bus.id_rd       = rd;
    bus.id_ctrl     = ctrl;
    bus.id_valid    = valid;
    bus.id_rs1_data = 32'hA000_0000 | 32'(rd);
    bus.id_rs2_data = 32'hB000_0000 | 32'(rd);
    bus.id_imm      = 32'hC000_0000 | 32'(rd);
    bus.id_pc       = 32'h0000_1000 + 32'(rd) * 4;
  endtask

  initial begin
    // 1. reset with random inputs
    rst = 1'b1;
    rst2 = 1'b1;
    drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 9'($urandom), 1'b1);
    bus.ex_flush = 1'b0;
    bus2.if_id_rs1 = 5'd3; bus2.if_id_rs2 = 5'd0; bus2.id_uses_rs1 = 1'b1; bus2.id_uses_rs2 = 1'b0;
    bus2.id_rd = 5'd3; bus2.id_ctrl = 9'h1A0; bus2.id_valid = 1'b1; bus2.ex_flush = 1'b0;
    bus2.id_rs1_data = '0; bus2.id_rs2_data = '0; bus2.id_imm = '0; bus2.id_pc = '0;
    tick();
    tick();
    chk("rst_rd",    64'(bus.id_ex_rd), 64'd0);
    chk("rst_rs1",   64'(bus.id_ex_rs1), 64'd0);
    chk("rst_ctrl",  64'(bus.id_ex_ctrl), 64'd0);
    chk("rst_valid", 64'(bus.id_ex_valid), 64'd0);
    chk("rst_data",  64'(bus.id_ex_rs1_data), 64'd0);
    chk("rst_pc",    64'(bus.id_ex_pc), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_cnt",   64'(bus.stall_count), 64'd0);

    // 2. pass-through
    rst = 1'b0;
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 9'h100, 1'b1);
    #1;
    chk("pt_stall_pre", 64'(bus.stall), 64'd0);
    tick();
    chk("pt_rd",    64'(bus.id_ex_rd), 64'd5);
    chk("pt_rs1",   64'(bus.id_ex_rs1), 64'd1);
    chk("pt_rs2",   64'(bus.id_ex_rs2), 64'd2);
    chk("pt_ctrl",  64'(bus.id_ex_ctrl), 64'h100);
    chk("pt_valid", 64'(bus.id_ex_valid), 64'd1);
    chk("pt_imm",   64'(bus.id_ex_imm), 64'hC000_0005);
    chk("pt_pc",    64'(bus.id_ex_pc), 64'h0000_1014);
    chk("pt_d2",    64'(bus.id_ex_rs2_data), 64'hB000_0005);

    // 3. load-use on rs2
    drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 9'h1A0, 1'b1);
    tick();
    drive(5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 9'h100, 1'b1);
    #1;
    chk("lu_stall", 64'(bus.stall), 64'd1);
    tick();
    chk("lu_bub_ctrl",  64'(bus.id_ex_ctrl), 64'd0);
    chk("lu_bub_rd",    64'(bus.id_ex_rd), 64'd0);
    chk("lu_bub_rs2",   64'(bus.id_ex_rs2), 64'd0);
    chk("lu_bub_valid", 64'(bus.id_ex_valid), 64'd0);
    chk("lu_cnt",       64'(bus.stall_count), 64'd1);
    chk("lu_stall_drop", 64'(bus.stall), 64'd0);
    tick();
    chk("lu_acc_rd",   64'(bus.id_ex_rd), 64'd8);
    chk("lu_acc_rs2",  64'(bus.id_ex_rs2), 64'd3);
    chk("lu_acc_ctrl", 64'(bus.id_ex_ctrl), 64'h100);
    chk("lu_acc_cnt",  64'(bus.stall_count), 64'd1);

    // 4. load to x0, then load whose rd is not actually read
    drive(5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 9'h1A0, 1'b1);
    tick();
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 9'h1A0, 1'b1);
    #1;
    chk("x0_stall", 64'(bus.stall), 64'd0);
    tick();
    drive(5'd4, 5'd6, 1'b0, 1'b1, 5'd9, 9'h100, 1'b1);
    #1;
    chk("unused_stall", 64'(bus.stall), 64'd0);
    tick();
    chk("unused_rd",  64'(bus.id_ex_rd), 64'd9);
    chk("unused_cnt", 64'(bus.stall_count), 64'd1);

    // 5. flush beats hazard
    drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 9'h1A0, 1'b1);
    tick();
    drive(5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 9'h100, 1'b1);
    bus.ex_flush = 1'b1;
    #1;
    chk("fl_stall", 64'(bus.stall), 64'd0);
    tick();
    chk("fl_ctrl",  64'(bus.id_ex_ctrl), 64'd0);
    chk("fl_rd",    64'(bus.id_ex_rd), 64'd0);
    chk("fl_valid", 64'(bus.id_ex_valid), 64'd0);
    chk("fl_pc",    64'(bus.id_ex_pc), 64'd0);
    chk("fl_cnt",   64'(bus.stall_count), 64'd1);
    bus.ex_flush = 1'b0;

    // invalid ID instruction: ctrl forced to zero, other fields pass
    drive(5'd2, 5'd0, 1'b0, 1'b0, 5'd10, 9'h1FF, 1'b0);
    tick();
    chk("inv_ctrl",  64'(bus.id_ex_ctrl), 64'd0);
    chk("inv_valid", 64'(bus.id_ex_valid), 64'd0);
    chk("inv_rd",    64'(bus.id_ex_rd), 64'd10);

    // reset during a stall
    drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 9'h1A0, 1'b1);
    tick();
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd8, 9'h100, 1'b1);
    #1;
    chk("ms_stall_pre", 64'(bus.stall), 64'd1);
    rst = 1'b1;
    tick();
    chk("ms_rd",    64'(bus.id_ex_rd), 64'd0);
    chk("ms_ctrl",  64'(bus.id_ex_ctrl), 64'd0);
    chk("ms_stall", 64'(bus.stall), 64'd0);
    chk("ms_cnt",   64'(bus.stall_count), 64'd0);
    rst = 1'b0;

    // 6. saturation with a 2-bit counter: a load that reads its own rd stalls every other cycle
    rst2 = 1'b0;
    repeat (4) tick();
    chk("sat_cnt_2", 64'(bus2.stall_count), 64'd2);
    repeat (9) tick();
    chk("sat_cnt_3", 64'(bus2.stall_count), 64'd3);
    tick();
    chk("sat_hold", 64'(bus2.stall_count), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
